pll_dyn_ctrl: RTL and testbench
===============================

PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
REQ-001 Parameter NUM_CH, 5, number of PLL output channels driven (1..5).
REQ-002 Parameter RATIO_W, 10, width of each ratio and duty field.
REQ-003 Parameter PHASE_W, 13, width of each phase field.
REQ-004 Parameter INIT_RATIO, 8, reset value of every ratio and duty field.
REQ-005 Parameter RST_CYCLES, 4, cycles pll_rst is held per lock attempt.
REQ-006 Parameter LOCK_STABLE, 8, consecutive synced-lock cycles required.
REQ-007 Parameter LOCK_TIMEOUT, 100, cycles allowed for lock per attempt.
REQ-008 Parameter MAX_RETRY, 2, extra attempts after the first.
REQ-009 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-010 clk  in  1  sole clock.
REQ-011 rst  in  1  asynchronous active-high reset.
REQ-012 cfg_valid  in  1  config beat valid.
REQ-013 cfg_ready  out  1  config beat accepted when valid&&ready.
REQ-014 cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
REQ-015 cfg_ratio, cfg_duty  in  RATIO_W each  new divider ratio and duty.
REQ-016 cfg_last  in  1  final beat of batch; triggers relock.
REQ-017 pll_lock  in  1  asynchronous PLL lock.
REQ-018 pll_rst  out  1  PLL reset.
REQ-019 dyn_odiv, dyn_duty  out  NUM_CH*RATIO_W each  applied ratios/duties, channel i at [i*RATIO_W +: RATIO_W].
REQ-020 clkout0_gate  out  1  clkout0 enable.
REQ-021 locked, busy, err  out  1 each  stable lock, sequence in progress, sticky failure.

Function
REQ-022 pll_lock SHALL pass a 2-flop synchronizer (lock_s) before any use.
REQ-023 States SHALL be ASSERT_RST, WAIT_LOCK, STABLE, IDLE, ERR.
REQ-024 cfg_ready SHALL be 1 only in IDLE and ERR.
REQ-025 Accepted beat with cfg_ch<NUM_CH SHALL write shadow registers only; dyn_* unchanged.
REQ-026 Accepted beat with cfg_ch>=NUM_CH SHALL be discarded, set err, and not trigger relock even if cfg_last=1.
REQ-027 Valid accepted beat with cfg_last=1 SHALL enter ASSERT_RST next cycle, clear err and retry count.
REQ-028 ASSERT_RST: pll_rst=1, clkout0_gate=0, locked=0; shadow copied to dyn_* on its first cycle; exits to WAIT_LOCK after RST_CYCLES cycles.
REQ-029 WAIT_LOCK: pll_rst=0; lock_s=1 -> STABLE; LOCK_TIMEOUT cycles without lock -> ASSERT_RST if retries<MAX_RETRY (retries+1), else ERR.
REQ-030 STABLE: LOCK_STABLE consecutive lock_s=1 -> IDLE; any lock_s=0 -> WAIT_LOCK with timeout counter restarted, retries unchanged.
REQ-031 IDLE: locked=1, clkout0_gate=1, busy=0; lock_s=0 -> WAIT_LOCK with locked=0, gate=0 same edge, retries cleared.
REQ-032 ERR: pll_rst=1, err=1, busy=0, gate=0; leaves only via REQ-027.
REQ-033 busy SHALL be 1 in ASSERT_RST, WAIT_LOCK, STABLE.
REQ-034 Counters SHALL saturate, never wrap; all outputs registered.

Reset
REQ-035 During rst: state ASSERT_RST, pll_rst=1, dyn_* and shadows = INIT_RATIO, gate=0, locked=0, err=0, busy=1, cfg_ready=0.
REQ-036 After rst release the power-up lock sequence SHALL run automatically from ASSERT_RST.
REQ-037 rst mid-sequence SHALL discard shadow writes not yet applied.

Configuration
REQ-038 Macro PLL_DYN_PHASE_EN defined: ports cfg_phase (in, PHASE_W) and dyn_phase (out, NUM_CH*PHASE_W) exist, shadowed/applied like ratios, reset 0.
REQ-039 PLL_DYN_PHASE_EN undefined: those ports and registers SHALL be absent; all else identical.

Verification
REQ-040 Power-up: release rst, pll_lock=1 from cycle 10 -> pll_rst high 4 cycles; locked and clkout0_gate rise 2+8 cycles after lock_s path sees lock.
REQ-041 Batch: ch1 ratio 16, ch3 ratio 160 (cfg_last on 2nd) -> dyn_odiv unchanged until first ASSERT_RST cycle, then both fields updated; relock completes.
REQ-042 pll_lock held 0 -> three 100-cycle attempts, then ERR, err=1, pll_rst=1, cfg_ready=1.
REQ-043 pll_lock drops 1 cycle at STABLE count 5 -> return to WAIT_LOCK, locked delayed a full 8 fresh stable cycles.
REQ-044 Lock loss in IDLE -> gate and locked drop 3 cycles after pll_lock falls; reacquire without pll_rst pulse.
REQ-045 cfg_ch=6, cfg_last=1 (NUM_CH=5) -> err=1, no dyn_* change, no relock.

Source files
------------

// File: rtl/pll_dyn_ctrl_if.sv
// Configuration beat bus for pll_dyn_ctrl: valid/ready handshake carrying per-channel
// divider settings. The phase field exists only when PLL_DYN_PHASE_EN is defined.
interface pll_dyn_ctrl_if #(
  parameter int NUM_CH  = 5,
  parameter int RATIO_W = 10,
  parameter int PHASE_W = 13
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch;
  logic [RATIO_W-1:0] cfg_ratio;
  logic [RATIO_W-1:0] cfg_duty;
  logic               cfg_last;
`ifdef PLL_DYN_PHASE_EN
  logic [PHASE_W-1:0] cfg_phase;
`endif

  modport master (
    output cfg_valid, cfg_ch, cfg_ratio, cfg_duty, cfg_last,
`ifdef PLL_DYN_PHASE_EN
    output cfg_phase,
`endif
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_ratio, cfg_duty, cfg_last,
`ifdef PLL_DYN_PHASE_EN
    input  cfg_phase,
`endif
    output cfg_ready
  );
endinterface

// File: rtl/pll_dyn_ctrl.sv
// Dynamic PLL reconfiguration controller: shadows per-channel settings, applies them
// under PLL reset, then supervises lock with retries. Optional phase fields: PLL_DYN_PHASE_EN.
module pll_dyn_ctrl #(
  parameter int NUM_CH       = 5,
  parameter int RATIO_W      = 10,
  parameter int PHASE_W      = 13,
  parameter int INIT_RATIO   = 8,
  parameter int RST_CYCLES   = 4,
  parameter int LOCK_STABLE  = 8,
  parameter int LOCK_TIMEOUT = 100,
  parameter int MAX_RETRY    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  pll_dyn_ctrl_if.slave             cfg,
  input  logic                      pll_lock,
  output logic                      pll_rst,
  output logic [NUM_CH*RATIO_W-1:0] dyn_odiv,
  output logic [NUM_CH*RATIO_W-1:0] dyn_duty,
`ifdef PLL_DYN_PHASE_EN
  output logic [NUM_CH*PHASE_W-1:0] dyn_phase,
`endif
  output logic                      clkout0_gate,
  output logic                      locked,
  output logic                      busy,
  output logic                      err
);

  localparam int CNT_MAX  = (LOCK_TIMEOUT > RST_CYCLES) ?
                            ((LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE) :
                            ((RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int RET_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RET_W-1:0] RET_MAX   = RET_W'(MAX_RETRY);

  localparam logic [NUM_CH*RATIO_W-1:0] INIT_VEC = {NUM_CH{RATIO_W'(INIT_RATIO)}};

  typedef enum logic [2:0] {
    ASSERT_RST,
    WAIT_LOCK,
    STABLE,
    IDLE,
    ERR
  } state_t;

  typedef struct packed {
    logic pll_rst;
    logic gate;
    logic locked;
    logic busy;
    logic ready;
  } outs_t;

  // Output pattern each state presents; loaded together with the state register.
  function automatic outs_t outs_for(input state_t s);
    case (s)
      ASSERT_RST: outs_for = '{pll_rst: 1'b1, gate: 1'b0, locked: 1'b0, busy: 1'b1, ready: 1'b0};
      IDLE:       outs_for = '{pll_rst: 1'b0, gate: 1'b1, locked: 1'b1, busy: 1'b0, ready: 1'b1};
      ERR:        outs_for = '{pll_rst: 1'b1, gate: 1'b0, locked: 1'b0, busy: 1'b0, ready: 1'b1};
      default:    outs_for = '{pll_rst: 1'b0, gate: 1'b0, locked: 1'b0, busy: 1'b1, ready: 1'b0};
    endcase
  endfunction

  state_t     state;
  outs_t      outs;
  logic [CNT_W-1:0] cnt;
  logic [RET_W-1:0] retry;
  logic       lock_meta;
  logic       lock_s;
  logic [NUM_CH*RATIO_W-1:0] sh_odiv;
  logic [NUM_CH*RATIO_W-1:0] sh_duty;
`ifdef PLL_DYN_PHASE_EN
  logic [NUM_CH*PHASE_W-1:0] sh_phase;
`endif

  logic beat;
  logic ch_ok;
  logic beat_ok;
  logic beat_bad;
  logic relock;

  assign beat     = cfg.cfg_valid && outs.ready;
  assign ch_ok    = int'(cfg.cfg_ch) < NUM_CH;
  assign beat_ok  = beat && ch_ok;
  assign beat_bad = beat && !ch_ok;
  assign relock   = beat_ok && cfg.cfg_last;

  assign cfg.cfg_ready = outs.ready;
  assign pll_rst       = outs.pll_rst;
  assign clkout0_gate  = outs.gate;
  assign locked        = outs.locked;
  assign busy          = outs.busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // Sequencer; shadows are written by accepted beats but reach dyn_* only in ASSERT_RST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ASSERT_RST;
      outs     <= outs_for(ASSERT_RST);
      cnt      <= '0;
      retry    <= '0;
      err      <= 1'b0;
      sh_odiv  <= INIT_VEC;
      sh_duty  <= INIT_VEC;
      dyn_odiv <= INIT_VEC;
      dyn_duty <= INIT_VEC;
`ifdef PLL_DYN_PHASE_EN
      sh_phase  <= '0;
      dyn_phase <= '0;
`endif
    end else begin
      if (beat_ok) begin
        sh_odiv[int'(cfg.cfg_ch)*RATIO_W +: RATIO_W] <= cfg.cfg_ratio;
        sh_duty[int'(cfg.cfg_ch)*RATIO_W +: RATIO_W] <= cfg.cfg_duty;
`ifdef PLL_DYN_PHASE_EN
        sh_phase[int'(cfg.cfg_ch)*PHASE_W +: PHASE_W] <= cfg.cfg_phase;
`endif
      end
      if (beat_bad) err <= 1'b1;

      case (state)
        ASSERT_RST: begin
          if (cnt == '0) begin
            dyn_odiv <= sh_odiv;
            dyn_duty <= sh_duty;
`ifdef PLL_DYN_PHASE_EN
            dyn_phase <= sh_phase;
`endif
          end
          if (cnt >= RST_LAST) begin
            state <= WAIT_LOCK;
            outs  <= outs_for(WAIT_LOCK);
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // The cycle that first sees lock_s counts as the first stable cycle.
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            outs  <= outs_for(STABLE);
            cnt   <= CNT_W'(1);
          end else if (cnt >= TO_LAST) begin
            cnt <= '0;
            if (retry < RET_MAX) begin
              retry <= retry + 1'b1;
              state <= ASSERT_RST;
              outs  <= outs_for(ASSERT_RST);
            end else begin
              state <= ERR;
              outs  <= outs_for(ERR);
              err   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            outs  <= outs_for(WAIT_LOCK);
            cnt   <= '0;
          end else if (cnt >= STAB_LAST) begin
            state <= IDLE;
            outs  <= outs_for(IDLE);
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        IDLE: begin
          if (relock) begin
            state <= ASSERT_RST;
            outs  <= outs_for(ASSERT_RST);
            cnt   <= '0;
            retry <= '0;
            err   <= 1'b0;
          end else if (!lock_s) begin
            state <= WAIT_LOCK;
            outs  <= outs_for(WAIT_LOCK);
            cnt   <= '0;
            retry <= '0;
          end
        end

        ERR: begin
          if (relock) begin
            state <= ASSERT_RST;
            outs  <= outs_for(ASSERT_RST);
            cnt   <= '0;
            retry <= '0;
            err   <= 1'b0;
          end
        end

        default: begin
          state <= ASSERT_RST;
          outs  <= outs_for(ASSERT_RST);
          cnt   <= '0;
          retry <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Directed testbench for pll_dyn_ctrl: power-up lock, batch reconfiguration, bad channel,
// lock loss, stable-count glitch, retry exhaustion to ERR and reset discarding shadows.
module tb_pll_dyn_ctrl;
  localparam int NUM_CH  = 5;
  localparam int RATIO_W = 10;
  localparam int PHASE_W = 13;

  logic clk = 1'b0;
  logic rst;
  logic pll_lock;
  logic pll_rst;
  logic [NUM_CH*RATIO_W-1:0] dyn_odiv;
  logic [NUM_CH*RATIO_W-1:0] dyn_duty;
`ifdef PLL_DYN_PHASE_EN
  logic [NUM_CH*PHASE_W-1:0] dyn_phase;
`endif
  logic clkout0_gate;
  logic locked;
  logic busy;
  logic err;

  int pass_count  = 0;
  int check_count = 0;

  logic [NUM_CH*RATIO_W-1:0] init_vec;
  logic [NUM_CH*RATIO_W-1:0] exp_odiv;
  logic [NUM_CH*RATIO_W-1:0] exp_duty;
  logic rst_seen;

  pll_dyn_ctrl_if #(.NUM_CH(NUM_CH), .RATIO_W(RATIO_W), .PHASE_W(PHASE_W)) cfg_bus ();

  pll_dyn_ctrl #(
    .NUM_CH(NUM_CH), .RATIO_W(RATIO_W), .PHASE_W(PHASE_W), .INIT_RATIO(8),
    .RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(100), .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg(cfg_bus.slave),
    .pll_lock(pll_lock),
    .pll_rst(pll_rst),
    .dyn_odiv(dyn_odiv),
    .dyn_duty(dyn_duty),
`ifdef PLL_DYN_PHASE_EN
    .dyn_phase(dyn_phase),
`endif
    .clkout0_gate(clkout0_gate),
    .locked(locked),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input int ch, input int ratio, input int duty, input logic last);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ch    = 3'(ch);
    cfg_bus.cfg_ratio = RATIO_W'(ratio);
    cfg_bus.cfg_duty  = RATIO_W'(duty);
    cfg_bus.cfg_last  = last;
`ifdef PLL_DYN_PHASE_EN
    cfg_bus.cfg_phase = '0;
`endif
    tick();
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_last  = 1'b0;
  endtask

  task automatic waitLocked(input string tag, input int budget);
    int n = 0;
    while (!locked && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, 64'(locked), 64'd1);
  endtask

  initial begin
    init_vec = {NUM_CH{10'd8}};
    rst = 1'b1;
    pll_lock = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_ch    = '0;
    cfg_bus.cfg_ratio = '0;
    cfg_bus.cfg_duty  = '0;
    cfg_bus.cfg_last  = 1'b0;
`ifdef PLL_DYN_PHASE_EN
    cfg_bus.cfg_phase = '0;
`endif
    tick(3);

    checkOutput("rst_pll_rst", 64'(pll_rst), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd1);
    checkOutput("rst_locked", 64'(locked), 64'd0);
    checkOutput("rst_gate", 64'(clkout0_gate), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_ready", 64'(cfg_bus.cfg_ready), 64'd0);
    checkOutput("rst_odiv", 64'(dyn_odiv), 64'(init_vec));
    checkOutput("rst_duty", 64'(dyn_duty), 64'(init_vec));

    // Power-up: pll_rst for 4 edges, lock applied after edge 10, locked on the 10th edge after.
    rst = 1'b0;
    tick(3);
    checkOutput("pwr_rst_hold", 64'(pll_rst), 64'd1);
    tick();
    checkOutput("pwr_rst_fall", 64'(pll_rst), 64'd0);
    checkOutput("pwr_busy", 64'(busy), 64'd1);
    tick(6);
    pll_lock = 1'b1;
    tick(9);
    checkOutput("pwr_not_yet", 64'(locked), 64'd0);
    tick();
    checkOutput("pwr_locked", 64'(locked), 64'd1);
    checkOutput("pwr_gate", 64'(clkout0_gate), 64'd1);
    checkOutput("pwr_busy_low", 64'(busy), 64'd0);
    checkOutput("pwr_ready", 64'(cfg_bus.cfg_ready), 64'd1);

    // Batch: ch1 and ch3 shadowed, applied only once the relock sequence starts.
    exp_odiv = init_vec;
    exp_duty = init_vec;
    exp_odiv[1*RATIO_W +: RATIO_W] = 10'd16;
    exp_duty[1*RATIO_W +: RATIO_W] = 10'd5;
    exp_odiv[3*RATIO_W +: RATIO_W] = 10'd160;
    exp_duty[3*RATIO_W +: RATIO_W] = 10'd80;
    applyStimulus(1, 16, 5, 1'b0);
    checkOutput("batch_shadow_only", 64'(dyn_odiv), 64'(init_vec));
    checkOutput("batch_idle", 64'(busy), 64'd0);
    applyStimulus(3, 160, 80, 1'b1);
    checkOutput("batch_rst", 64'(pll_rst), 64'd1);
    tick(2);
    checkOutput("batch_odiv", 64'(dyn_odiv), 64'(exp_odiv));
    checkOutput("batch_duty", 64'(dyn_duty), 64'(exp_duty));
    waitLocked("batch_relock", 50);
    checkOutput("batch_pll_rst_low", 64'(pll_rst), 64'd0);

    // Out-of-range channel: discarded, err set, no relock.
    applyStimulus(6, 99, 99, 1'b1);
    checkOutput("badch_err", 64'(err), 64'd1);
    checkOutput("badch_busy", 64'(busy), 64'd0);
    checkOutput("badch_pll_rst", 64'(pll_rst), 64'd0);
    checkOutput("badch_odiv", 64'(dyn_odiv), 64'(exp_odiv));
    tick(5);
    checkOutput("badch_still_locked", 64'(locked), 64'd1);
    checkOutput("badch_still_idle", 64'(busy), 64'd0);

    // Lock loss in IDLE: drop visible on the 3rd edge, reacquire with no pll_rst pulse.
    pll_lock = 1'b0;
    tick(2);
    checkOutput("loss_still_locked", 64'(locked), 64'd1);
    tick();
    checkOutput("loss_locked_low", 64'(locked), 64'd0);
    checkOutput("loss_gate_low", 64'(clkout0_gate), 64'd0);
    pll_lock = 1'b1;
    rst_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (pll_rst) rst_seen = 1'b1;
    end
    checkOutput("reacq_not_yet", 64'(locked), 64'd0);
    tick();
    checkOutput("reacq_locked", 64'(locked), 64'd1);
    checkOutput("reacq_no_pll_rst", 64'(rst_seen), 64'd0);

    // One-cycle lock glitch at stable count 5 forces a full fresh 8-cycle qualification.
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    tick(7);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick(2);
    checkOutput("glitch_no_lock", 64'(locked), 64'd0);
    tick(7);
    checkOutput("glitch_fresh_wait", 64'(locked), 64'd0);
    tick();
    checkOutput("glitch_relocked", 64'(locked), 64'd1);

    // Lock never arrives: three attempts of 4 + 100 cycles, ERR on edge 312.
    pll_lock = 1'b0;
    applyStimulus(0, 8, 8, 1'b1);
    checkOutput("retry_err_cleared", 64'(err), 64'd0);
    checkOutput("retry_busy", 64'(busy), 64'd1);
    tick(311);
    checkOutput("retry_not_err_yet", 64'(err), 64'd0);
    checkOutput("retry_busy_yet", 64'(busy), 64'd1);
    tick();
    checkOutput("err_flag", 64'(err), 64'd1);
    checkOutput("err_pll_rst", 64'(pll_rst), 64'd1);
    checkOutput("err_ready", 64'(cfg_bus.cfg_ready), 64'd1);
    checkOutput("err_busy", 64'(busy), 64'd0);
    checkOutput("err_gate", 64'(clkout0_gate), 64'd0);

    // Shadow write in ERR, then reset: the pending write must never be applied.
    applyStimulus(2, 50, 50, 1'b0);
    checkOutput("err_sticky", 64'(err), 64'd1);
    rst = 1'b1;
    tick();
    checkOutput("rst2_odiv", 64'(dyn_odiv), 64'(init_vec));
    checkOutput("rst2_err", 64'(err), 64'd0);
    rst = 1'b0;
    pll_lock = 1'b1;
    waitLocked("rst2_relock", 60);
    checkOutput("rst2_shadow_discarded", 64'(dyn_odiv), 64'(init_vec));
    checkOutput("rst2_duty", 64'(dyn_duty), 64'(init_vec));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
